// File: rtl/controlador_estados.sv
// Pet behaviour state machine feeding controlador_atributos: buttons + attributes -> estado.
// Latency: a button edge sampled at clock edge N updates estado/ocupado at edge N (visible next cycle).
// Backpressure: none; button levels are edge-detected, and during timed activities events are dropped.
// Optional feature (macro CONTROLADOR_ESTADOS_CANCELA_EN): re-pressing the button that started an
// activity cancels it back to IDLE.
module controlador_estados #(
  parameter int TICK_CICLOS   = 8388608,
  parameter int DURACAO_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_dormir,
  input  logic       btn_comer,
  input  logic       btn_aula,
  input  logic [7:0] fome,
  input  logic [7:0] felicidade,
  input  logic [7:0] sono,
  output logic [4:0] estado,
  output logic       ocupado
);

  localparam int TW = (TICK_CICLOS > 1) ? $clog2(TICK_CICLOS) : 1;

  localparam logic [4:0] INTRO      = 5'b00000;
  localparam logic [4:0] IDLE       = 5'b00001;
  localparam logic [4:0] DORMINDO   = 5'b00010;
  localparam logic [4:0] COMENDO    = 5'b00100;
  localparam logic [4:0] DANDO_AULA = 5'b01000;
  localparam logic [4:0] MORTO      = 5'b10000;

  localparam logic [TW-1:0] TICK_ULT = TW'(TICK_CICLOS - 1);
  localparam logic [7:0]    DUR_ULT  = 8'(DURACAO_TICKS - 1);

  // Button order in the vectors below: {aula, comer, dormir, start}
  logic [3:0]    btn;
  logic [3:0]    hist;
  logic [3:0]    ev;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_nxt;
  logic [7:0]    dur_cnt;
  logic [7:0]    dur_nxt;
  logic [4:0]    estado_nxt;
  logic          ocupado_nxt;
  logic          zero_attr;
  logic          em_atividade;
  logic          tick_wrap;
  logic          expira;
  logic          cancela;

  assign btn          = {btn_aula, btn_comer, btn_dormir, btn_start};
  assign ev           = btn & ~hist;
  assign zero_attr    = (fome == 8'd0) | (felicidade == 8'd0) | (sono == 8'd0);
  assign em_atividade = (estado == DORMINDO) | (estado == COMENDO) | (estado == DANDO_AULA);
  assign tick_wrap    = (tick_cnt == TICK_ULT);
  // Last cycle of the activity: final tick of the final duration period
  assign expira       = em_atividade & tick_wrap & (dur_cnt == DUR_ULT);

`ifdef CONTROLADOR_ESTADOS_CANCELA_EN
  assign cancela = ((estado == DORMINDO)   & ev[1]) |
                   ((estado == COMENDO)    & ev[2]) |
                   ((estado == DANDO_AULA) & ev[3]);
`else
  assign cancela = 1'b0;
`endif

  // State register: estado, ocupado, counters and button history update together
  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= INTRO;
      ocupado  <= 1'b0;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      hist     <= btn;  // a button held through reset must not fire on release
    end else begin
      estado   <= estado_nxt;
      ocupado  <= ocupado_nxt;
      tick_cnt <= tick_nxt;
      dur_cnt  <= dur_nxt;
      hist     <= btn;
    end
  end

  // Next-state logic: death first, then per-state transitions
  always_comb begin
    estado_nxt = estado;
    case (estado)
      INTRO: begin
        if (ev[0] && !zero_attr) estado_nxt = IDLE;
      end
      IDLE: begin
        if (zero_attr)  estado_nxt = MORTO;
        else if (ev[1]) estado_nxt = DORMINDO;
        else if (ev[2]) estado_nxt = COMENDO;
        else if (ev[3]) estado_nxt = DANDO_AULA;
      end
      DORMINDO, COMENDO, DANDO_AULA: begin
        if (zero_attr)             estado_nxt = MORTO;
        else if (expira || cancela) estado_nxt = IDLE;
      end
      MORTO: begin
        if (ev[0]) estado_nxt = INTRO;
      end
      default: estado_nxt = INTRO;
    endcase
  end

  // Output/counter logic: counters run only while staying in an activity, cleared otherwise
  always_comb begin
    ocupado_nxt = (estado_nxt == DORMINDO) | (estado_nxt == COMENDO) | (estado_nxt == DANDO_AULA);
    tick_nxt    = '0;
    dur_nxt     = '0;
    if (ocupado_nxt && (estado_nxt == estado)) begin
      tick_nxt = tick_wrap ? '0 : tick_cnt + TW'(1);
      dur_nxt  = tick_wrap ? dur_cnt + 8'd1 : dur_cnt;
    end
  end

endmodule

// File: tb/tb_controlador_estados.sv
// Directed bench for controlador_estados with TICK_CICLOS=4, DURACAO_TICKS=3 (12-cycle activities).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Each task checks {estado, ocupado} against hand-computed values.
module tb_controlador_estados;

  localparam logic [4:0] INTRO      = 5'b00000;
  localparam logic [4:0] IDLE       = 5'b00001;
  localparam logic [4:0] DORMINDO   = 5'b00010;
  localparam logic [4:0] COMENDO    = 5'b00100;
  localparam logic [4:0] DANDO_AULA = 5'b01000;
  localparam logic [4:0] MORTO      = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start, btn_dormir, btn_comer, btn_aula;
  logic [7:0] fome, felicidade, sono;
  logic [4:0] estado;
  logic       ocupado;

  int vectors = 0;
  int errors  = 0;

  controlador_estados #(.TICK_CICLOS(4), .DURACAO_TICKS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_dormir (btn_dormir),
    .btn_comer  (btn_comer),
    .btn_aula   (btn_aula),
    .fome       (fome),
    .felicidade (felicidade),
    .sono       (sono),
    .estado     (estado),
    .ocupado    (ocupado)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; btn_start = 1'b1; btn_dormir = 1'b0; btn_comer = 1'b0; btn_aula = 1'b0;
    fome = 8'd80; felicidade = 8'd50; sono = 8'd70;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({estado, ocupado} !== {INTRO, 1'b0}) begin
        errors++;
        $display("FAIL reset_held_start[%0d]: got estado=%b ocupado=%b, want %b 0", i, estado, ocupado, INTRO);
      end
    end
    btn_start = 1'b0;
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    vectors++;
    if ({estado, ocupado} !== {IDLE, 1'b0}) begin
      errors++;
      $display("FAIL start_to_idle: got estado=%b ocupado=%b, want %b 0", estado, ocupado, IDLE);
    end
  endtask

  task automatic test_timed_activity();
    btn_comer = 1'b1;
    @(negedge clk);
    btn_comer = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      vectors++;
      if ({estado, ocupado} !== {COMENDO, 1'b1}) begin
        errors++;
        $display("FAIL comendo_cycle%0d: got estado=%b ocupado=%b, want %b 1", c, estado, ocupado, COMENDO);
      end
      if (c == 5) btn_dormir = 1'b1;
      if (c == 6) btn_dormir = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if ({estado, ocupado} !== {IDLE, 1'b0}) begin
      errors++;
      $display("FAIL comendo_expiry: got estado=%b ocupado=%b, want %b 0", estado, ocupado, IDLE);
    end
  endtask

  task automatic test_priority();
    btn_dormir = 1'b1; btn_comer = 1'b1; btn_aula = 1'b1;
    @(negedge clk);
    vectors++;
    if ({estado, ocupado} !== {DORMINDO, 1'b1}) begin
      errors++;
      $display("FAIL priority_dormir: got estado=%b ocupado=%b, want %b 1", estado, ocupado, DORMINDO);
    end
    repeat (11) @(negedge clk);
    vectors++;
    if (estado !== DORMINDO) begin
      errors++;
      $display("FAIL dormindo_last_cycle: got estado=%b, want %b", estado, DORMINDO);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({estado, ocupado} !== {IDLE, 1'b0}) begin
        errors++;
        $display("FAIL held_no_retrigger[%0d]: got estado=%b ocupado=%b, want %b 0", i, estado, ocupado, IDLE);
      end
    end
    btn_dormir = 1'b0; btn_comer = 1'b0; btn_aula = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_death();
    btn_aula = 1'b1;
    @(negedge clk);
    btn_aula = 1'b0;
    vectors++;
    if ({estado, ocupado} !== {DANDO_AULA, 1'b1}) begin
      errors++;
      $display("FAIL enter_aula: got estado=%b ocupado=%b, want %b 1", estado, ocupado, DANDO_AULA);
    end
    repeat (11) @(negedge clk);
    // now in the 12th and final activity cycle: the coming edge is the expiry edge
    sono = 8'd0;
    @(negedge clk);
    vectors++;
    if ({estado, ocupado} !== {MORTO, 1'b0}) begin
      errors++;
      $display("FAIL death_over_expiry: got estado=%b ocupado=%b, want %b 0", estado, ocupado, MORTO);
    end
    btn_comer = 1'b1;
    @(negedge clk);
    btn_comer = 1'b0;
    vectors++;
    if (estado !== MORTO) begin
      errors++;
      $display("FAIL morto_ignores_comer: got estado=%b, want %b", estado, MORTO);
    end
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    vectors++;
    if (estado !== INTRO) begin
      errors++;
      $display("FAIL morto_start_intro: got estado=%b, want %b", estado, INTRO);
    end
    sono = 8'd70;
    @(negedge clk);
  endtask

  task automatic test_restart_guard();
    fome = 8'd0;
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    vectors++;
    if (estado !== INTRO) begin
      errors++;
      $display("FAIL start_blocked_zero: got estado=%b, want %b", estado, INTRO);
    end
    fome = 8'd80;
    @(negedge clk);
    vectors++;
    if (estado !== INTRO) begin
      errors++;
      $display("FAIL start_not_queued: got estado=%b, want %b", estado, INTRO);
    end
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    vectors++;
    if (estado !== IDLE) begin
      errors++;
      $display("FAIL restart_to_idle: got estado=%b, want %b", estado, IDLE);
    end
  endtask

  task automatic test_cancel();
    btn_dormir = 1'b1;
    @(negedge clk);                 // cycle 1 of DORMINDO
    btn_dormir = 1'b0;
    btn_aula   = 1'b1;
    @(negedge clk);                 // cycle 2
    btn_aula   = 1'b0;
    vectors++;
    if (estado !== DORMINDO) begin
      errors++;
      $display("FAIL aula_ignored_in_dormindo: got estado=%b, want %b", estado, DORMINDO);
    end
    repeat (2) @(negedge clk);      // cycle 4
    btn_dormir = 1'b1;
    @(negedge clk);                 // cycle 5
    btn_dormir = 1'b0;
`ifdef CONTROLADOR_ESTADOS_CANCELA_EN
    vectors++;
    if ({estado, ocupado} !== {IDLE, 1'b0}) begin
      errors++;
      $display("FAIL cancel_to_idle: got estado=%b ocupado=%b, want %b 0", estado, ocupado, IDLE);
    end
`else
    vectors++;
    if ({estado, ocupado} !== {DORMINDO, 1'b1}) begin
      errors++;
      $display("FAIL repress_ignored: got estado=%b ocupado=%b, want %b 1", estado, ocupado, DORMINDO);
    end
    repeat (7) @(negedge clk);      // cycle 12
    vectors++;
    if (estado !== DORMINDO) begin
      errors++;
      $display("FAIL dormindo_cycle12: got estado=%b, want %b", estado, DORMINDO);
    end
    @(negedge clk);
    vectors++;
    if ({estado, ocupado} !== {IDLE, 1'b0}) begin
      errors++;
      $display("FAIL dormindo_expiry: got estado=%b ocupado=%b, want %b 0", estado, ocupado, IDLE);
    end
`endif
  endtask

  task automatic test_reset_abort();
    btn_comer = 1'b1;
    @(negedge clk);
    vectors++;
    if (estado !== COMENDO) begin
      errors++;
      $display("FAIL enter_comer_before_abort: got estado=%b, want %b", estado, COMENDO);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({estado, ocupado} !== {INTRO, 1'b0}) begin
      errors++;
      $display("FAIL reset_aborts_activity: got estado=%b ocupado=%b, want %b 0", estado, ocupado, INTRO);
    end
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    @(negedge clk);
    vectors++;
    if (estado !== IDLE) begin
      errors++;
      $display("FAIL held_comer_after_reset: got estado=%b, want %b", estado, IDLE);
    end
    btn_comer = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timed_activity();
    test_priority();
    test_death();
    test_restart_guard();
    test_cancel();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
